// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states, access-size codes and byte-lane masks for mem_stage
package mem_pkg;

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] SZ_B = 8'd8;
    localparam logic [7:0] SZ_H = 8'd16;
    localparam logic [7:0] SZ_W = 8'd32;
    localparam logic [7:0] SZ_D = 8'd64;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // Unknown size codes fall through to a full doubleword
    function automatic logic [7:0] size_mask(input logic [7:0] size);
        return size == SZ_B ? MASK_B : size == SZ_H ? MASK_H : size == SZ_W ? MASK_W : MASK_D;
    endfunction

    // Aligned when no offset bit falls inside the access width
    function automatic logic is_aligned(input logic [2:0] off, input logic [7:0] size);
        return (off & (size == SZ_B ? 3'd0 : size == SZ_H ? 3'd1 : size == SZ_W ? 3'd3 : 3'd7)) == 3'd0;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus between mem_stage and memory
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/ldst_align.sv
// ldst_align: store lane shift/strobe and load lane shift/extend (lanes past byte 7 drop)
module ldst_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_off,
    input  logic [7:0]  st_size,
    input  logic [63:0] st_data,
    output logic [63:0] st_wdata,
    output logic [7:0]  st_wstrb,
    input  logic [2:0]  ld_off,
    input  logic [7:0]  ld_size,
    input  logic        ld_unsign,
    input  logic [63:0] ld_raw,
    output logic [63:0] ld_data
);

    logic [63:0] sh;
    logic        sx;

    // Move store data up to its byte lane; move load data down and extend
    always_comb begin
        st_wdata = st_data << {st_off, 3'b000};
        st_wstrb = size_mask(st_size) << st_off;
        sh       = ld_raw >> {ld_off, 3'b000};
        sx       = ~ld_unsign;
        ld_data  = ld_size == SZ_B ? {{56{sx & sh[7]}}, sh[7:0]}
                 : ld_size == SZ_H ? {{48{sx & sh[15]}}, sh[15:0]}
                 : ld_size == SZ_W ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with IDLE/WAIT handshake and ack timeout; MEM_MISALIGN_CHECK_EN rejects misaligned accesses
module mem_stage
    import mem_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXMEM_ready,
    input  logic        mem_active,
    input  logic        load,
    input  logic [7:0]  ldst_size,
    input  logic        ldst_unsign,
    input  logic [63:0] exmm_aluresult,
    input  logic [63:0] EXMEM_rs2,
    input  logic [5:0]  dest_reg,
    input  logic        EXMEM_wbactive,
    input  logic        EXMEM_ecall,
    output logic        MEMEX_stall,
    output logic [5:0]  MEMEX_rd,
    output logic [63:0] MEMEX_rdval,
    output logic        MEMEX_wbactive,
    mem_stage_if.master dmem,
    output logic        MEMWB_ready,
    output logic [5:0]  MEMWB_rd,
    output logic [63:0] MEMWB_rdval,
    output logic        MEMWB_wbactive,
    output logic        MEMWB_ecall,
    output logic        mem_err
);

    localparam logic [15:0] TO_LAST = 16'(DMEM_TIMEOUT - 1);

    state_t      state, state_n;
    logic [15:0] cnt;
    logic        accept, misalign, go_wait, timeout, done, wb_in;
    logic [2:0]  op_off;
    logic [7:0]  op_size;
    logic        op_unsign, op_load, op_wb, op_ecall;
    logic [5:0]  op_rd;
    logic [63:0] st_wdata, ld_data;
    logic [7:0]  st_wstrb;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = mem_active && !is_aligned(exmm_aluresult[2:0], ldst_size);
`else
    assign misalign = 1'b0;
`endif

    assign accept         = state == IDLE && EXMEM_ready;
    assign wb_in          = (mem_active ? load : EXMEM_wbactive) && dest_reg != 6'd0;
    assign MEMEX_rd       = MEMWB_rd;
    assign MEMEX_rdval    = MEMWB_rdval;
    assign MEMEX_wbactive = MEMWB_wbactive & MEMWB_ready;

    ldst_align u_align (
        .st_off    (exmm_aluresult[2:0]),
        .st_size   (ldst_size),
        .st_data   (EXMEM_rs2),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .ld_off    (op_off),
        .ld_size   (op_size),
        .ld_unsign (op_unsign),
        .ld_raw    (dmem.dmem_rdata),
        .ld_data   (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    // Next state: memory ops park in WAIT until ack or timeout
    always_comb begin
        go_wait     = accept && mem_active && !misalign;
        timeout     = state == WAIT && !dmem.dmem_ack && cnt == TO_LAST;
        done        = state == WAIT && (dmem.dmem_ack || timeout);
        state_n     = state == IDLE ? (go_wait ? WAIT : IDLE) : (done ? IDLE : WAIT);
        MEMEX_stall = state == WAIT;
    end

    // Request issue, op capture and completion results
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_wstrb <= '0;
            cnt             <= '0;
            op_off          <= '0;
            op_size         <= '0;
            op_unsign       <= 1'b0;
            op_load         <= 1'b0;
            op_wb           <= 1'b0;
            op_ecall        <= 1'b0;
            op_rd           <= '0;
            MEMWB_ready     <= 1'b0;
            MEMWB_rd        <= '0;
            MEMWB_rdval     <= '0;
            MEMWB_wbactive  <= 1'b0;
            MEMWB_ecall     <= 1'b0;
            mem_err         <= 1'b0;
        end else begin
            MEMWB_ready <= 1'b0;
            mem_err     <= 1'b0;
            cnt         <= state == WAIT && !done ? cnt + 16'd1 : '0;
            if (go_wait) begin
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= ~load;
                dmem.dmem_addr  <= {exmm_aluresult[63:3], 3'b000};
                dmem.dmem_wdata <= st_wdata;
                dmem.dmem_wstrb <= load ? 8'h00 : st_wstrb;
                op_off          <= exmm_aluresult[2:0];
                op_size         <= ldst_size;
                op_unsign       <= ldst_unsign;
                op_load         <= load;
                op_wb           <= wb_in;
                op_ecall        <= EXMEM_ecall;
                op_rd           <= dest_reg;
            end else if (accept) begin
                MEMWB_ready    <= 1'b1;
                MEMWB_rd       <= dest_reg;
                MEMWB_ecall    <= EXMEM_ecall;
                MEMWB_rdval    <= misalign ? 64'd0 : exmm_aluresult;
                MEMWB_wbactive <= wb_in && !misalign;
                mem_err        <= misalign;
            end else if (done) begin
                dmem.dmem_req  <= 1'b0;
                MEMWB_ready    <= 1'b1;
                MEMWB_rd       <= op_rd;
                MEMWB_ecall    <= op_ecall;
                MEMWB_rdval    <= dmem.dmem_ack && op_load ? ld_data : 64'd0;
                MEMWB_wbactive <= dmem.dmem_ack && op_wb;
                mem_err        <= timeout;
            end
        end
    end

endmodule
